// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between decode (master) and the immediate-extension stage (slave).
// Latency: none, wires only.
// Backpressure: carries in_ready/out_ready; the slave owns in_ready, out_valid, out_data.
//
// Signals:
//   in_valid/in_ready/in_data/in_mode  : upstream beat (raw immediate + extension mode)
//   out_valid/out_ready/out_data       : downstream result (extended immediate)
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    // Upstream/downstream side: presents beats, accepts results.
    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_mode,
        input  out_valid,
        output out_ready,
        input  out_data
    );

    // Extension stage side.
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_mode,
        output out_valid,
        input  out_ready,
        output out_data
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extension (sign / zero / upper / branch-offset) for the MIPS datapath.
// Latency: 1 cycle from accept to out_data when the stage is empty.
// Backpressure: 2-entry skid (main + skid reg); in_ready drops only when both are full, from state alone.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush, discards held entries and any beat offered that cycle
//   occupancy  number of held entries (0, 1, 2)
//   bus        imm_extend_pipe_if.slave: in_valid/in_ready/in_data/in_mode, out_valid/out_ready/out_data
//
// Build option: define EXTEND_BRANCH_EN to make mode 11 the branch-offset
// extension (sign-extend then shift left 2). Without it mode 11 is plain
// sign extension and no shifter is built.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    output logic [1:0]          occupancy,
    imm_extend_pipe_if.slave    bus
);

    // ------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------
    // The branch mode drops the top two bits of the sign-extended value,
    // so at least two bits of headroom above IN_W are required.
    generate
        if (IN_W < 2) begin : g_bad_in_w
            $error("imm_extend_pipe: IN_W must be >= 2");
        end
        if (OUT_W < IN_W + 2) begin : g_bad_out_w
            $error("imm_extend_pipe: OUT_W must be >= IN_W+2");
        end
    endgenerate

    localparam int PAD_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    state_t           state_q;
    state_t           state_d;
    logic [OUT_W-1:0] main_q;
    logic [OUT_W-1:0] skid_q;

    logic             accept;
    logic             consume;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;

    // ------------------------------------------------------------------
    // Extension datapath (ahead of the registers)
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] ext_dat;

    always_comb begin
        sign_ext  = {{PAD_W{bus.in_data[IN_W-1]}}, bus.in_data};
        zero_ext  = {{PAD_W{1'b0}}, bus.in_data};
        upper_ext = {bus.in_data, {PAD_W{1'b0}}};
    end

`ifdef EXTEND_BRANCH_EN
    logic [OUT_W-1:0] branch_ext;

    // Word-offset branch target: sign-extended immediate times four.
    // The two MSBs of sign_ext fall off; they are copies of the sign
    // bit because PAD_W >= 2, so no information is lost.
    always_comb begin
        branch_ext = {sign_ext[OUT_W-3:0], 2'b00};
    end
`endif

    // Mode bits are only meaningful on accept; X/undriven values while
    // in_valid=0 fall through to the default arm and are never stored.
    always_comb begin
        ext_dat = sign_ext;
        case (bus.in_mode)
            MODE_SIGN:   ext_dat = sign_ext;
            MODE_ZERO:   ext_dat = zero_ext;
            MODE_UPPER:  ext_dat = upper_ext;
`ifdef EXTEND_BRANCH_EN
            MODE_BRANCH: ext_dat = branch_ext;
`else
            MODE_BRANCH: ext_dat = sign_ext;
`endif
            default:     ext_dat = sign_ext;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // in_ready and out_valid are pure decodes of the state register, so
    // neither has a combinational path from out_ready or in_valid.
    always_comb begin
        bus.in_ready  = (state_q != TWO);
        bus.out_valid = (state_q != EMPTY);
        bus.out_data  = main_q;
        occupancy     = state_q;
    end

    always_comb begin
        accept  = bus.in_valid  && bus.in_ready;
        consume = bus.out_valid && bus.out_ready;
    end

    // ------------------------------------------------------------------
    // Next-state and register-load control
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;

        if (flush) begin
            // Flush wins over accept and consume; main_q is left alone so
            // out_data keeps its last value while out_valid is low.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end else if (accept) begin
                        // Main entry is still waiting; park the new beat
                        // behind it to preserve order.
                        skid_load = 1'b1;
                        state_d   = TWO;
                    end else if (consume) begin
                        state_d   = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a consume can happen.
                    if (consume) begin
                        main_from_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else if (main_from_skid) begin
            main_q <= skid_q;
        end else if (main_load) begin
            main_q <= ext_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (skid_load) begin
            skid_q <= ext_dat;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed/table-driven bench for imm_extend_pipe (IN_W=16, OUT_W=32).
// Latency: checks results one cycle after accept.
// Backpressure: exercises skid fill, stall, drain, toggling ready, flush and async reset.
module tb_imm_extend_pipe;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [1:0] occupancy;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .occupancy (occupancy),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference extension written arithmetically rather than bitwise.
    function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
        int          sv;
        logic [31:0] r;
        sv = int'($signed(d));
        case (m)
            2'b00: r = sv;
            2'b01: r = 32'(d);
            2'b10: r = 32'(d) * 32'h10000;
`ifdef EXTEND_BRANCH_EN
            default: r = sv * 4;
`else
            default: r = sv;
`endif
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic [31:0] e;
    } vec_t;

    vec_t tv[11];

    logic [31:0] q[$];
    logic [31:0] exp_a;

    initial begin
        tv[0]  = '{16'h0001, 2'b00, 32'h00000001};
        tv[1]  = '{16'h1234, 2'b00, 32'h00001234};
        tv[2]  = '{16'hFFFF, 2'b00, 32'hFFFFFFFF};
        tv[3]  = '{16'h8000, 2'b00, 32'hFFFF8000};
        tv[4]  = '{16'h0000, 2'b00, 32'h00000000};
        tv[5]  = '{16'h8000, 2'b01, 32'h00008000};
        tv[6]  = '{16'h1234, 2'b10, 32'h12340000};
`ifdef EXTEND_BRANCH_EN
        tv[7]  = '{16'hFFFE, 2'b11, 32'hFFFFFFF8};
        tv[8]  = '{16'h7FFF, 2'b11, 32'h0001FFFC};
`else
        tv[7]  = '{16'hFFFE, 2'b11, 32'hFFFFFFFE};
        tv[8]  = '{16'h7FFF, 2'b11, 32'h00007FFF};
`endif
        tv[9]  = '{16'hFFFF, 2'b10, 32'hFFFF0000};
        tv[10] = '{16'hFFFF, 2'b01, 32'h0000FFFF};

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b1;

        // ---------------- reset state ----------------
        #12;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  bus.out_data,           32'd0);
        chk("rst_occupancy", {30'b0, occupancy},     32'd0);
        chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---------------- table: back-to-back beats, all modes ----------------
        for (int i = 0; i < 11; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tv[i].d;
            bus.in_mode  = tv[i].m;
            step();
            chk($sformatf("vec%0d_data", i),  bus.out_data,           tv[i].e);
            chk($sformatf("vec%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("vec%0d_occ", i),   {30'b0, occupancy},     32'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_mode  = 2'bxx;
        step();
        chk("drain_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("drain_occ",   {30'b0, occupancy},     32'd0);
        bus.in_mode = 2'b00;

        // ---------------- backpressure: A,B held, C stalled ----------------
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0011;
        step();
        chk("bp_occ_a",      {30'b0, occupancy},    32'd1);
        chk("bp_rdy_a",      {31'b0, bus.in_ready}, 32'd1);
        bus.in_data = 16'h8002;
        step();
        chk("bp_occ_ab",     {30'b0, occupancy},    32'd2);
        chk("bp_rdy_ab",     {31'b0, bus.in_ready}, 32'd0);
        chk("bp_data_ab",    bus.out_data,          32'h00000011);
        bus.in_data = 16'h0033;
        step();
        chk("bp_occ_stall",  {30'b0, occupancy},    32'd2);
        chk("bp_data_stall", bus.out_data,          32'h00000011);
        bus.out_ready = 1'b1;
        step();
        chk("bp_out_b",      bus.out_data,          32'hFFFF8002);
        chk("bp_occ_b",      {30'b0, occupancy},    32'd1);
        step();
        chk("bp_out_c",      bus.out_data,          32'h00000033);
        chk("bp_occ_c",      {30'b0, occupancy},    32'd1);
        bus.in_valid = 1'b0;
        step();
        chk("bp_empty",      {31'b0, bus.out_valid}, 32'd0);

        // ---------------- throughput with toggling out_ready ----------------
        begin
            int          acc;
            int          cyc;
            logic [15:0] d;
            logic [1:0]  m;
            logic        do_acc;
            logic        do_con;
            acc = 0;
            cyc = 0;
            q.delete();
            while ((acc < 20 || q.size() > 0) && cyc < 300) begin
                chk("tp_occ",   {30'b0, occupancy},     32'(q.size()));
                chk("tp_rdy",   {31'b0, bus.in_ready},  {31'b0, q.size() < 2});
                chk("tp_valid", {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
                d = 16'($urandom);
                m = 2'($urandom_range(0, 3));
                bus.in_valid  = (acc < 20);
                bus.in_data   = d;
                bus.in_mode   = m;
                bus.out_ready = (cyc % 2 == 1);
                do_con = (q.size() > 0) && bus.out_ready;
                do_acc = bus.in_valid && (q.size() < 2);
                if (do_con) begin
                    chk("tp_data", bus.out_data, q[0]);
                    void'(q.pop_front());
                end
                if (do_acc) begin
                    q.push_back(model(d, m));
                    acc++;
                end
                step();
                cyc++;
            end
            checks++;
            if (acc < 20 || q.size() > 0) begin
                errors++;
                $display("FAIL tp_timeout accepted=%0d required=20 left=%0d", acc, q.size());
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();

        // ---------------- flush with two held entries ----------------
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h00A1;
        bus.in_mode   = 2'b00;
        step();
        bus.in_data = 16'h00B2;
        step();
        chk("fl_occ_pre", {30'b0, occupancy}, 32'd2);
        exp_a = 32'h000000A1;
        flush = 1'b1;
        bus.in_data = 16'h00C3;
        step();
        flush = 1'b0;
        chk("fl_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("fl_occ",   {30'b0, occupancy},     32'd0);
        chk("fl_rdy",   {31'b0, bus.in_ready},  32'd1);
        chk("fl_data",  bus.out_data,           exp_a);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("fl_dropped", {31'b0, bus.out_valid}, 32'd0);

        // ---------------- async reset mid-stream ----------------
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h5555;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        chk("ar_occ_pre",  {30'b0, occupancy}, 32'd1);
        chk("ar_data_pre", bus.out_data,       32'h00005555);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("ar_data",  bus.out_data,           32'd0);
        chk("ar_occ",   {30'b0, occupancy},     32'd0);
        chk("ar_rdy",   {31'b0, bus.in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
